exec_button_conditioner: RTL and testbench
==========================================

// Module: exec_button_conditioner
// PURPOSE
//  Conditions the raw, asynchronous, bouncing EXEC pushbutton into a clean single-cycle EXEC pulse.
//  Feeds the clock-gating control unit's EXEC input, so that unit never sees chatter or metastable input.
//  Also outputs the debounced button level and a running count of accepted presses for debug LEDs.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive stable cycles needed to accept a press/release (>=1)
//  COUNT_W          8    width of PRESS_COUNT
//  REPEAT_DELAY     10   cycles from press EXEC to first auto-repeat EXEC (EXEC_AUTOREPEAT_EN only)
//  REPEAT_PERIOD    5    cycles between subsequent auto-repeat EXECs (EXEC_AUTOREPEAT_EN only)
// PORTS
//  CLOCK        in   1        single system clock, all logic on rising edge
//  RESET        in   1        synchronous, active-high reset
//  BTN_RAW      in   1        raw pushbutton, active-high, asynchronous to CLOCK
//  EXEC         out  1        one-cycle pulse per accepted press, registered
//  BTN_LEVEL    out  1        debounced button level, registered
//  PRESS_COUNT  out  COUNT_W  number of EXEC pulses issued, wraps 2^COUNT_W-1 -> 0
// BEHAVIOUR
//  Reset: sync flops=0, state=IDLE, debounce cnt=0, EXEC=0, BTN_LEVEL=0, PRESS_COUNT=0. RESET overrides all.
//  Input: 2-flop synchronizer on BTN_RAW gives btn_s. The FSM uses btn_s only.
//  FSM states (2-bit):
//   IDLE:         btn_s=1 -> PRESS_WAIT, cnt<=0
//   PRESS_WAIT:   btn_s=0 -> IDLE (bounce rejected); else cnt++.
//                 cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD; EXEC<=1, BTN_LEVEL<=1, PRESS_COUNT++
//   HELD:         btn_s=0 -> RELEASE_WAIT, cnt<=0
//   RELEASE_WAIT: btn_s=1 -> HELD (no EXEC, no count); else cnt++.
//                 cnt==DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE; BTN_LEVEL<=0
//  Latency: take the first edge that samples BTN_RAW=1 as edge 0. EXEC is high after edge DEBOUNCE_CYCLES+2.
//   Release to BTN_LEVEL=0 uses the same timing.
//  Glitch filter: a BTN_RAW high pulse of L cycles produces EXEC iff L >= DEBOUNCE_CYCLES+1.
//  EXEC is high for exactly 1 cycle. There is never more than one EXEC per debounced press (unless auto-repeat is enabled).
//  RESET mid-press: FSM returns to IDLE and no EXEC is issued. A button still held after reset is debounced again from scratch and yields one EXEC.
//  Simultaneous: the RESET edge dominates any transition in the same cycle. A PRESS_COUNT increment and wrap happen in the same cycle as EXEC.
//  Counter widths: cnt is $clog2(DEBOUNCE_CYCLES+1) bits, saturating logic is not needed because of the state exits.
// CONFIGURATION
//  Macro EXEC_AUTOREPEAT_EN:
//   defined: in HELD a repeat counter runs.
//    First extra EXEC comes REPEAT_DELAY cycles after the press EXEC, then one every REPEAT_PERIOD cycles while in HELD.
//    Each extra EXEC increments PRESS_COUNT.
//    Leaving HELD clears the repeat counter. Re-entering HELD from RELEASE_WAIT restarts REPEAT_DELAY.
//   undefined: no repeat logic is synthesized, REPEAT_* are unused, and HELD emits no EXEC.
// STRUCTURE
//  Package exec_cond_pkg holds:
//   state typedef: IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3
//   default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD
//  Sub-module sync_2ff: a 2-flop synchronizer with sync reset, reusable for the RESET button path.
//  All other logic (FSM, counters) lives inline.
// TESTING (DEBOUNCE_CYCLES=4, COUNT_W=8)
//  1 RESET=1 for 2 cycles with BTN_RAW=1 -> EXEC=0, BTN_LEVEL=0, PRESS_COUNT=0 while in reset.
//  2 BTN_RAW 0->1 held 20 cycles, then 0 -> EXEC high exactly at edge 6 for 1 cycle.
//    BTN_LEVEL=1 from edge 6. PRESS_COUNT=1. BTN_LEVEL=0 at 6 edges after the release sample.
//  3 Glitches: 4-cycle high pulse -> no EXEC. 5-cycle pulse -> one EXEC.
//    1/0 chatter of 2-cycle segments followed by stable high -> one EXEC, PRESS_COUNT=1.
//  4 Release chatter: during HELD drop BTN_RAW 3 cycles then back high -> no EXEC, BTN_LEVEL stays 1.
//  5 RESET asserted at edge 4 of a press, button kept high -> no EXEC before reset.
//    One EXEC at edge 6 counted from the first post-reset sample.
//  6 256 clean presses -> PRESS_COUNT returns to 0. With EXEC_AUTOREPEAT_EN, hold 30 cycles after press EXEC
//    -> extra EXECs at +10,+15,+20,+25,+30. Without the macro -> only the press EXEC.

Source files
------------

// File: rtl/exec_cond_pkg.sv
// Shared types and default constants for the EXEC pushbutton conditioner.
// The repeat defaults only matter when EXEC_AUTOREPEAT_EN is defined.
package exec_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_COUNT_W         = 8;
    localparam int DEF_REPEAT_DELAY    = 10;
    localparam int DEF_REPEAT_PERIOD   = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous reset.
// Used for the EXEC button and reusable for the RESET button path.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exec_button_conditioner.sv
// Debounces the raw EXEC pushbutton into a single-cycle EXEC pulse, a clean level and a press counter.
// Optional macro EXEC_AUTOREPEAT_EN adds auto-repeat EXEC pulses while the button stays held.
module exec_button_conditioner
    import exec_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COUNT_W         = DEF_COUNT_W
`ifdef EXEC_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               BTN_RAW,
    output logic               EXEC,
    output logic               BTN_LEVEL,
    output logic [COUNT_W-1:0] PRESS_COUNT,
    output logic [1:0]         STATE_DBG
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               btn_s;
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               exec_n, level_n;
    logic [COUNT_W-1:0] count_n;

    sync_2ff #(.WIDTH(1)) u_btn_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .d     (BTN_RAW),
        .q     (btn_s)
    );

`ifdef EXEC_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // rpt_first selects the initial delay; after the first repeat the period applies
    logic [RPT_W-1:0] rpt_cnt, rpt_n, rpt_last;
    logic             rpt_first, first_n;

    assign rpt_last = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_n;
            rpt_first <= first_n;
        end
    end
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            EXEC        <= 1'b0;
            BTN_LEVEL   <= 1'b0;
            PRESS_COUNT <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            EXEC        <= exec_n;
            BTN_LEVEL   <= level_n;
            PRESS_COUNT <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        exec_n  = 1'b0;
        level_n = BTN_LEVEL;
        count_n = PRESS_COUNT;
`ifdef EXEC_AUTOREPEAT_EN
        rpt_n   = '0;
        first_n = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    exec_n  = 1'b1;
                    level_n = 1'b1;
                    count_n = PRESS_COUNT + COUNT_W'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
`ifdef EXEC_AUTOREPEAT_EN
                else if (rpt_cnt == rpt_last) begin
                    exec_n  = 1'b1;
                    count_n = PRESS_COUNT + COUNT_W'(1);
                    rpt_n   = '0;
                    first_n = 1'b0;
                end else begin
                    rpt_n   = rpt_cnt + RPT_W'(1);
                    first_n = rpt_first;
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to high returns to HELD silently: same press, no new EXEC
                if (btn_s) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign STATE_DBG = state;

endmodule

// File: tb/tb_exec_button_conditioner.sv
// Self-checking bench for exec_button_conditioner: vector table, directed corner sequences,
// and a randomized run against a run-length reference model of the debounce rules.
module tb_exec_button_conditioner;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN_RAW = 1'b0;
    logic       EXEC;
    logic       BTN_LEVEL;
    logic [7:0] PRESS_COUNT;
    logic [1:0] STATE_DBG;

    int tests_run = 0;
    int failures  = 0;

    exec_button_conditioner #(.DEBOUNCE_CYCLES(DC), .COUNT_W(8)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .BTN_RAW     (BTN_RAW),
        .EXEC        (EXEC),
        .BTN_LEVEL   (BTN_LEVEL),
        .PRESS_COUNT (PRESS_COUNT),
        .STATE_DBG   (STATE_DBG)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: debounced level flips after DC+1 consecutive opposite samples
    bit         m_hist[$];
    int         m_level, m_run, m_hold;
    int         m_exec;
    logic [7:0] m_count;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit raw, input bit rst);
        bit s;
        m_exec = 0;
        if (rst) begin
            m_hist  = '{1'b0, 1'b0};
            m_level = 0;
            m_run   = 0;
            m_hold  = 0;
            m_count = 8'd0;
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(raw);
            if (int'(s) != m_level) begin
                m_run++;
                if (m_run == DC + 1) begin
                    m_level = int'(s);
                    m_run   = 0;
                    m_hold  = 0;
                    if (s) begin
                        m_exec  = 1;
                        m_count = m_count + 8'd1;
                    end
                end
            end else begin
                if (m_level == 1) begin
                    if (m_run > 0) begin
                        m_hold = 0;
                    end else begin
                        m_hold++;
`ifdef EXEC_AUTOREPEAT_EN
                        if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) begin
                            m_exec  = 1;
                            m_count = m_count + 8'd1;
                        end
`endif
                    end
                end
                m_run = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input bit raw, input bit rst);
        @(negedge CLOCK);
        BTN_RAW = raw;
        RESET   = rst;
        @(posedge CLOCK);
        #1;
        model_edge(raw, rst);
        check("model_exec", int'(EXEC), m_exec);
        check("model_level", int'(BTN_LEVEL), m_level);
        check("model_count", int'(PRESS_COUNT), int'(m_count));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    typedef struct {
        int hi_len;
        int exp_execs;
    } pulse_vec_t;

    pulse_vec_t vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_exec;

    initial begin
        vecs[0] = '{1, 0};
        vecs[1] = '{3, 0};
        vecs[2] = '{4, 0};
        vecs[3] = '{5, 1};
        vecs[4] = '{6, 1};
        vecs[5] = '{14, 1};

        // Reset with the button held: outputs stay cleared
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1);
            check("rst_exec", int'(EXEC), 0);
            check("rst_level", int'(BTN_LEVEL), 0);
            check("rst_count", int'(PRESS_COUNT), 0);
            check("rst_state", int'(STATE_DBG), 0);
        end

        // Clean press: EXEC exactly after edge 6, level drops 6 edges after the release sample
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            if (k < 8) check("press_exec_edge", int'(EXEC), (k == 6) ? 1 : 0);
            if (k < 8) check("press_level_edge", int'(BTN_LEVEL), (k >= 6) ? 1 : 0);
        end
`ifndef EXEC_AUTOREPEAT_EN
        check("press_count", int'(PRESS_COUNT), 1);
`endif
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0);
            check("release_level_edge", int'(BTN_LEVEL), (k < 6) ? 1 : 0);
        end

        // Pulse-length table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            n_exec = 0;
            for (int k = 0; k < vecs[v].hi_len; k++) begin
                step(1'b1, 1'b0);
                n_exec += int'(EXEC);
            end
            for (int k = 0; k < 12; k++) begin
                step(1'b0, 1'b0);
                n_exec += int'(EXEC);
            end
            check($sformatf("pulse_len%0d_execs", vecs[v].hi_len), n_exec, vecs[v].exp_execs);
            check($sformatf("pulse_len%0d_count", vecs[v].hi_len), int'(PRESS_COUNT), vecs[v].exp_execs);
        end

        // Press chatter of 2-cycle segments, then stable high
        do_reset();
        n_exec = 0;
        for (int k = 0; k < 8; k++) begin
            step(((k / 2) % 2) == 0, 1'b0);
            n_exec += int'(EXEC);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0);
            n_exec += int'(EXEC);
        end
        check("chatter_execs", n_exec, 1);
        check("chatter_count", int'(PRESS_COUNT), 1);

        // Release chatter while held: no new EXEC, level stays high
        do_reset();
        for (int k = 0; k < 9; k++) step(1'b1, 1'b0);
        n_exec = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            n_exec += int'(EXEC);
            check("rel_chatter_level", int'(BTN_LEVEL), 1);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0);
            n_exec += int'(EXEC);
            check("rel_chatter_level", int'(BTN_LEVEL), 1);
        end
        check("rel_chatter_execs", n_exec, 0);

        // Reset at edge 4 of a press, button kept high
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            check("midrst_pre_exec", int'(EXEC), 0);
        end
        step(1'b1, 1'b1);
        check("midrst_exec", int'(EXEC), 0);
        check("midrst_state", int'(STATE_DBG), 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            check("midrst_post_exec", int'(EXEC), (k == 6) ? 1 : 0);
        end
        check("midrst_count", int'(PRESS_COUNT), 1);

        // 256 clean presses wrap the counter
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
            for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        end
        check("wrap_count", int'(PRESS_COUNT), 0);

        // Long hold: auto-repeat schedule relative to the first sample
        do_reset();
        exp_q.delete();
        got_q.delete();
        exp_q.push_back(8'd6);
`ifdef EXEC_AUTOREPEAT_EN
        for (int r = 0; r < 5; r++) exp_q.push_back(8'(6 + RD + r * RP));
`endif
        for (int k = 0; k < 48; k++) begin
            step(k < 38, 1'b0);
            if (EXEC) got_q.push_back(8'(k));
        end
        check("hold_exec_total", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("hold_exec_edge", int'(got_q.pop_front()), int'(exp_q.pop_front()));
        end

        // Randomized runs with occasional resets, checked every cycle by the model
        do_reset();
        for (int seg = 0; seg < 600; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                step(lvl, $urandom_range(0, 199) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
